// File: rtl/divisor_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of the step counter, which must hold WIDTH-1.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/restoring_step.sv
// One compare/subtract/restore iteration of the restoring division algorithm.
module restoring_step
  import divisor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             d_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // The trial difference is WIDTH+1 bits wide. Whichever value is kept is below
  // the divisor, so the stored partial remainder needs only WIDTH bits.
  always_comb begin
    shifted_s = {p_i, d_msb_i};
    trial_s   = shifted_s - {1'b0, b_i};
    if (trial_s[WIDTH] == 1'b0) begin
      p_o     = trial_s[WIDTH-1:0];
      q_bit_o = 1'b1;
    end else begin
      p_o     = shifted_s[WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/divisor_restoring_param.sv
// Sequential restoring divider producing one quotient bit per clock.
// Optional signed mode is enabled by defining DIVISOR_SIGNED_EN.
module divisor_restoring_param
  import divisor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
`ifdef DIVISOR_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int             CW       = count_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;

  logic             accept_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] step_p_s;
  logic             step_q_bit_s;
  logic [WIDTH-1:0] q_raw_s;
  logic [WIDTH-1:0] q_res_s;
  logic [WIDTH-1:0] r_res_s;

  assign accept_s = (state_q == IDLE) && start;

  restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i     (p_q),
    .d_msb_i (d_q[WIDTH-1]),
    .b_i     (b_q),
    .p_o     (step_p_s),
    .q_bit_o (step_q_bit_s)
  );

  assign q_raw_s = {d_q[WIDTH-2:0], step_q_bit_s};

`ifdef DIVISOR_SIGNED_EN
  logic a_neg_s;
  logic b_neg_s;
  logic neg_q_q;
  logic neg_r_q;

  // Magnitudes feed the unsigned core; the most negative value maps onto itself.
  always_comb begin
    a_neg_s = signed_op & A_in[WIDTH-1];
    b_neg_s = signed_op & B_in[WIDTH-1];
    a_mag_s = a_neg_s ? (ZERO_W - A_in) : A_in;
    b_mag_s = b_neg_s ? (ZERO_W - B_in) : B_in;
  end

  // Sign-fix flags captured with the operands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept_s) begin
      neg_q_q <= a_neg_s ^ b_neg_s;
      neg_r_q <= a_neg_s;
    end else begin
      neg_q_q <= neg_q_q;
      neg_r_q <= neg_r_q;
    end
  end

  // Sign correction folded into the final step so no extra cycle is needed.
  always_comb begin
    q_res_s = neg_q_q ? (ZERO_W - q_raw_s) : q_raw_s;
    r_res_s = neg_r_q ? (ZERO_W - step_p_s) : step_p_s;
  end
`else
  // Unsigned only: operands feed the core unchanged.
  always_comb begin
    a_mag_s = A_in;
    b_mag_s = B_in;
    q_res_s = q_raw_s;
    r_res_s = step_p_s;
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    d_d     = d_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B_in == ZERO_W) begin
            state_d = DONE;
            q_d     = ONES_W;
            r_d     = A_in;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            count_d = CNT_LAST;
            p_d     = ZERO_W;
            d_d     = a_mag_s;
            b_d     = b_mag_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d = step_p_s;
        d_d = q_raw_s;
        if (count_q == CNT_ZERO) begin
          state_d = DONE;
          q_d     = q_res_s;
          r_d     = r_res_s;
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= CNT_ZERO;
      p_q     <= ZERO_W;
      d_q     <= ZERO_W;
      b_q     <= ZERO_W;
      q_q     <= ZERO_W;
      r_q     <= ZERO_W;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      d_q     <= d_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor_restoring_param.sv
// Directed bench for divisor_restoring_param at WIDTH 7 and 16 (and 8 signed
// when DIVISOR_SIGNED_EN is defined).
module tb_divisor_restoring_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        st7 = 1'b0, sg7 = 1'b0;
  logic [6:0]  a7 = '0, b7 = '0, q7, r7;
  logic        done7, busy7, dz7;
  logic        st16 = 1'b0, sg16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic        done16, busy16, dz16;

  int n_checks = 0;
  int n_fails  = 0;
  bit seen_done;

  divisor_restoring_param #(.WIDTH(7)) u_w7 (
    .clk(clk), .rst(rst), .start(st7), .A_in(a7), .B_in(b7),
`ifdef DIVISOR_SIGNED_EN
    .signed_op(sg7),
`endif
    .Q(q7), .R(r7), .done(done7), .busy(busy7), .div_zero(dz7)
  );

  divisor_restoring_param #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st16), .A_in(a16), .B_in(b16),
`ifdef DIVISOR_SIGNED_EN
    .signed_op(sg16),
`endif
    .Q(q16), .R(r16), .done(done16), .busy(busy16), .div_zero(dz16)
  );

`ifdef DIVISOR_SIGNED_EN
  logic       st8 = 1'b0, sg8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic       done8, busy8, dz8;

  divisor_restoring_param #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .A_in(a8), .B_in(b8), .signed_op(sg8),
    .Q(q8), .R(r8), .done(done8), .busy(busy8), .div_zero(dz8)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic sg);
    case (inst)
      7:  begin st7 = st;  a7 = a[6:0];   b7 = b[6:0];   sg7 = sg;  end
      16: begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; sg16 = sg; end
`ifdef DIVISOR_SIGNED_EN
      8:  begin st8 = st;  a8 = a[7:0];   b8 = b[7:0];   sg8 = sg;  end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] get_q(input int inst);
    case (inst)
      7:  return {25'd0, q7};
      16: return {16'd0, q16};
`ifdef DIVISOR_SIGNED_EN
      8:  return {24'd0, q8};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] get_r(input int inst);
    case (inst)
      7:  return {25'd0, r7};
      16: return {16'd0, r16};
`ifdef DIVISOR_SIGNED_EN
      8:  return {24'd0, r8};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Packs {div_zero, busy, done} for one instance.
  function automatic logic [2:0] get_flags(input int inst);
    case (inst)
      7:  return {dz7, busy7, done7};
      16: return {dz16, busy16, done16};
`ifdef DIVISOR_SIGNED_EN
      8:  return {dz8, busy8, done8};
`endif
      default: return 3'd0;
    endcase
  endfunction

  task automatic run(input int inst, input logic [31:0] a, input logic [31:0] b,
                     input logic sg, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int elat, input string tag);
    int  lat;
    bit  seen;
    logic [2:0] fl;
    lat  = 0;
    seen = 1'b0;
    drive(inst, 1'b1, a, b, sg);
    @(posedge clk);
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) drive(inst, 1'b0, a, b, sg);
      lat = k;
      fl  = get_flags(inst);
      if (fl[0]) seen = 1'b1;
    end
    fl = get_flags(inst);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_Q"}, get_q(inst), eq);
    check({tag, "_R"}, get_r(inst), er);
    check({tag, "_divzero"}, {31'd0, fl[2]}, {31'd0, edz});
    check({tag, "_busy_in_done"}, {31'd0, fl[1]}, 32'd1);
    @(negedge clk);
    fl = get_flags(inst);
    check({tag, "_after_done_busy_done"}, {30'd0, fl[1:0]}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_Q7", get_q(7), 32'd0);
    check("reset_R7", get_r(7), 32'd0);
    check("reset_flags7", {29'd0, get_flags(7)}, 32'd0);
    check("reset_Q16", get_q(16), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run(7, 7, 2, 1'b0, 3, 1, 1'b0, 8, "w7_7_2");
    run(7, 50, 7, 1'b0, 7, 1, 1'b0, 8, "w7_50_7");
    run(7, 127, 13, 1'b0, 9, 10, 1'b0, 8, "w7_127_13");
    run(7, 99, 5, 1'b0, 19, 4, 1'b0, 8, "w7_99_5");
    run(7, 45, 0, 1'b0, 127, 45, 1'b1, 1, "w7_div0");
    run(7, 7, 2, 1'b0, 3, 1, 1'b0, 8, "w7_clear_dz");

    run(16, 50000, 7, 1'b0, 7142, 6, 1'b0, 17, "w16_50000_7");
    run(16, 65535, 65535, 1'b0, 1, 0, 1'b0, 17, "w16_max_max");
    run(16, 3, 200, 1'b0, 0, 3, 1'b0, 17, "w16_3_200");

    // A start pulse while busy must not disturb the operation in flight.
    begin
      int lat;
      lat = 0;
      seen_done = 1'b0;
      drive(7, 1'b1, 127, 13, 1'b0);
      @(posedge clk);
      for (int k = 1; k <= 40 && !seen_done; k++) begin
        @(negedge clk);
        if (k == 1) drive(7, 1'b0, 127, 13, 1'b0);
        if (k == 3) drive(7, 1'b1, 50, 7, 1'b0);
        if (k == 4) drive(7, 1'b0, 50, 7, 1'b0);
        lat = k;
        if (done7) seen_done = 1'b1;
      end
      check("ignore_start_latency", lat, 32'd8);
      check("ignore_start_Q", get_q(7), 32'd9);
      check("ignore_start_R", get_r(7), 32'd10);
      @(negedge clk);
      check("ignore_start_idle", {31'd0, busy7}, 32'd0);
    end

    // Start held high: back-to-back results are WIDTH+2 cycles apart.
    begin
      int gap;
      gap = 0;
      seen_done = 1'b0;
      drive(7, 1'b1, 50, 7, 1'b0);
      for (int k = 1; k <= 30 && !seen_done; k++) begin
        @(negedge clk);
        if (done7) seen_done = 1'b1;
      end
      check("hold_first_done", {31'd0, seen_done}, 32'd1);
      seen_done = 1'b0;
      for (int k = 1; k <= 30 && !seen_done; k++) begin
        @(negedge clk);
        gap = k;
        if (done7) seen_done = 1'b1;
      end
      drive(7, 1'b0, 50, 7, 1'b0);
      check("hold_gap", gap, 32'd9);
      check("hold_Q", get_q(7), 32'd7);
      check("hold_R", get_r(7), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("hold_stopped", {29'd0, get_flags(7)}, 32'd0);
    end

    // Reset during an operation aborts it without a done pulse.
    seen_done = 1'b0;
    drive(7, 1'b1, 50, 7, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(7, 1'b0, 50, 7, 1'b0);
      if (done7) seen_done = 1'b1;
      if (k == 4) rst = 1'b0;
    end
    @(negedge clk);
    check("midrst_no_done", {31'd0, seen_done}, 32'd0);
    check("midrst_Q", get_q(7), 32'd0);
    check("midrst_R", get_r(7), 32'd0);
    check("midrst_flags", {29'd0, get_flags(7)}, 32'd0);
    @(negedge clk);
    check("midrst_still_quiet", {29'd0, get_flags(7)}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run(7, 7, 2, 1'b0, 3, 1, 1'b0, 8, "w7_after_rst");

`ifdef DIVISOR_SIGNED_EN
    run(8, 32'hF9, 32'h02, 1'b1, 32'hFD, 32'hFF, 1'b0, 9, "w8s_m7_2");
    run(8, 32'h07, 32'hFE, 1'b1, 32'hFD, 32'h01, 1'b0, 9, "w8s_7_m2");
    run(8, 32'h80, 32'hFF, 1'b1, 32'h80, 32'h00, 1'b0, 9, "w8s_min_m1");
    run(8, 32'hF9, 32'h02, 1'b0, 32'h7C, 32'h01, 1'b0, 9, "w8u_249_2");
    run(8, 32'hF9, 32'h00, 1'b1, 32'hFF, 32'hF9, 1'b1, 1, "w8s_div0");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/divisor_restoring_param.md
# divisor_restoring_param

Parametrised sequential restoring divider, the generalisation of the fixed 7-bit divider. It computes one quotient bit per clock for a configurable operand width. It flags divide-by-zero and exposes a busy level, with an optional signed mode. It sits behind the top-level datapath controller, which issues `start` and waits for the `done` pulse.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width; legal range 2..32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-low reset; sampled on `clk` rising edge.
- `start` input 1: request; accepted only while idle.
- `A_in` input WIDTH: dividend; sampled in the accept cycle only.
- `B_in` input WIDTH: divisor; sampled in the accept cycle only.
- `signed_op` input 1: present only when `DIVISOR_SIGNED_EN` is defined; sampled with the operands.
- `Q` output WIDTH: quotient; registered and held until the next result.
- `R` output WIDTH: remainder; registered and held until the next result.
- `done` output 1: one-cycle pulse; `Q`, `R` and `div_zero` are valid from this cycle on.
- `busy` output 1: high from the cycle after accept through the `done` cycle inclusive.
- `div_zero` output 1: registered with the result; high when the divisor was 0.

## Operation
- FSM states:
  - IDLE: `start`=1 latches the operands. If `B_in`≠0 go to CALC; if `B_in`=0 go to DONE.
  - CALC: `count` runs from WIDTH-1 down to 0. After the step at `count`=0, go to DONE.
  - DONE: asserts `done` and returns to IDLE.
- Per-step algorithm, using a WIDTH+1-bit partial remainder `P` and a WIDTH-bit shift register `D`:
  - Form `T = {P[WIDTH-1:0], D[WIDTH-1]} - {1'b0, B}`.
  - If `T[WIDTH]`=0: `P=T` and the quotient bit is 1. Otherwise `P` is restored (shifted only) and the quotient bit is 0.
  - `D` shifts left, and the quotient bit enters at the LSB.
- Divide-by-zero result: `Q` = all ones, `R` = `A_in`, `div_zero`=1.
- `start` while `busy` is ignored. It is neither queued nor does it disturb the operation in flight.
- `start` held high continuously: a new operation is accepted in the first IDLE cycle after each DONE.
- Reset mid-operation: the operation is aborted, no `done` is produced, and all state returns to reset values on the next edge.
- Reset values: `Q`=0, `R`=0, `done`=0, `busy`=0, `div_zero`=0, state IDLE, `count`=0.

## Timing
- Let cycle t be the accept cycle (IDLE and `start`=1 at the edge).
- Nonzero divisor: CALC spans cycles t+1 … t+WIDTH, and `done` fires at t+WIDTH+1. Latency is WIDTH+1 cycles.
- Zero divisor: `done` fires at t+1.
- Throughput: at most one result per WIDTH+2 cycles, because IDLE is always visited for at least one cycle.
- `busy` falls in the cycle after `done`, which is the same cycle a new `start` can be accepted.

## Configuration
- Macro: `DIVISOR_SIGNED_EN`.
- Defined: the `signed_op` port exists.
  - With `signed_op`=1, operands are two's complement. The magnitudes are divided unsigned.
  - The quotient truncates toward zero and is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - −2^(WIDTH-1) / −1 yields `Q` = −2^(WIDTH-1), `R`=0 (wrap), with no flag.
  - Sign correction is registered in the DONE transition and adds no cycles.
  - Divide-by-zero in signed mode returns `Q` = all ones, `R` = `A_in`.
- Undefined: there is no `signed_op` port, the block is unsigned only, and no sign logic is synthesised.

## Structure
- `divisor_pkg` holds the state enum typedef `div_state_t` (IDLE, CALC, DONE) and the `count` width function `$clog2(WIDTH)`.
- The sub-module `restoring_step` is purely combinational and parametrised by WIDTH. It computes one compare/subtract/restore iteration and returns the next `P` and the quotient bit.
- The top module holds the FSM, the operand and result registers, and the optional sign logic.

## Test plan
- WIDTH=7: 7/2, 50/7, 127/13, 99/5 → Q/R = 3/1, 7/1, 9/10, 19/4. Each `done` arrives exactly 8 cycles after accept, with `div_zero`=0.
- WIDTH=7: B=0, A=45 → at t+1 `done`=1, Q=127, R=45, `div_zero`=1. The next nonzero divide clears `div_zero`.
- WIDTH=16: 50000/7 → Q=7142, R=6, with `done` at t+17. 65535/65535 → Q=1, R=0. 3/200 → Q=0, R=3.
- WIDTH=7: a second `start` with different operands at t+3 → it is ignored, and the first result 127/13 → 9/10 is unchanged.
- WIDTH=7: `rst`=0 at t+4 of 50/7 → no `done` appears, all outputs are 0 the next cycle, and a fresh 7/2 → 3/1 completes after reset is released.
- WIDTH=8 with `DIVISOR_SIGNED_EN`: −7/2 → Q=−3, R=−1. 7/−2 → Q=−3, R=1. −128/−1 → Q=−128, R=0. `signed_op`=0 with 249/2 → Q=124, R=1.
